// File: rtl/ion_packet_serializer_pkg.sv
// Shared types and constants for the ion packet serializer: entry geometry,
// FSM state encoding and helpers for stream selection and byte extraction.
package ion_packet_serializer_pkg;

    localparam int         PKT_W          = 110;
    localparam int         ENTRY_W        = 113;
    localparam int         BYTES_PER_PKT  = 15;
    localparam logic [4:0] HEADER_DEFAULT = 5'b10110;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        SEND = 2'b10
    } state_t;

    // Index of the lowest set flag; the lowest stream wins when several are ready.
    function automatic logic [2:0] lowest_set(input logic [7:0] flags);
        logic [2:0] id;
        id = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (flags[i]) id = 3'(i);
        end
        return id;
    endfunction

    // Byte 0 is {header, id}; bytes 1..14 walk {data, 2'b00} from the MSB down.
    function automatic logic [7:0] packet_byte(input logic [4:0]         header,
                                               input logic [ENTRY_W-1:0] entry,
                                               input logic [3:0]         idx);
        logic [PKT_W+1:0] padded;
        logic [7:0]       result;
        padded = {entry[PKT_W-1:0], 2'b00};
        if (idx == 4'd0) begin
            result = {header, entry[ENTRY_W-1 -: 3]};
        end else begin
            result = 8'(padded >> (8 * (BYTES_PER_PKT - 1 - int'(idx))));
        end
        return result;
    endfunction

endpackage

// File: rtl/ion_packet_serializer_fifo.sv
// Circular packet buffer: DEPTH entries of WIDTH bits with an occupancy count.
// A push into a full buffer is refused even when a pop happens in the same cycle.
module packet_fifo
    import ion_packet_serializer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [4:0]       count,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == 5'(DEPTH));
    assign empty    = (count == 5'd0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: storage has no reset; count and pointers alone decide which slots are valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 5'd0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + 5'(do_push) - 5'(do_pop);
        end
    end

endmodule

// File: rtl/ion_packet_serializer.sv
// Captures one sensor packet per strobe into a FIFO and streams each as
// 15 bytes (sync header + id, then 110 data bits padded to 112) to a UART.
module ion_packet_serializer
    import ion_packet_serializer_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [4:0] HEADER     = HEADER_DEFAULT
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [7:0]       ready,
    input  logic             data_valid,
    input  logic [PKT_W-1:0] data_in0,
    input  logic [PKT_W-1:0] data_in1,
    input  logic [PKT_W-1:0] data_in2,
    input  logic [PKT_W-1:0] data_in3,
    input  logic [PKT_W-1:0] data_in4,
    input  logic [PKT_W-1:0] data_in5,
    input  logic [PKT_W-1:0] data_in6,
    input  logic [PKT_W-1:0] data_in7,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic [4:0]       fifo_count,
    output logic             overflow
);

    state_t             state;
    logic [ENTRY_W-1:0] hold;
    logic [3:0]         byte_idx;

    logic               capture;
    logic [2:0]         cap_id;
    logic [PKT_W-1:0]   cap_data;
    logic [ENTRY_W-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;

    assign capture = data_valid && (ready != 8'h00);
    assign pop     = (state == LOAD);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cap_id   = lowest_set(ready);
        cap_data = data_in0;
        case (cap_id)
            3'd0: cap_data = data_in0;
            3'd1: cap_data = data_in1;
            3'd2: cap_data = data_in2;
            3'd3: cap_data = data_in3;
            3'd4: cap_data = data_in4;
            3'd5: cap_data = data_in5;
            3'd6: cap_data = data_in6;
            3'd7: cap_data = data_in7;
            default: cap_data = data_in0;
        endcase
    end

    packet_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .push      (capture),
        .push_data ({cap_id, cap_data}),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (capture && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    // tx_data is loaded one byte ahead so the UART sees a registered, stable value.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            hold     <= '0;
            byte_idx <= 4'd0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    if (!fifo_empty) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    hold     <= head;
                    byte_idx <= 4'd0;
                    tx_data  <= packet_byte(HEADER, head, 4'd0);
                    tx_valid <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (tx_ready) begin
                        if (byte_idx == 4'(BYTES_PER_PKT - 1)) begin
                            state    <= IDLE;
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            byte_idx <= 4'd0;
                        end else begin
                            byte_idx <= byte_idx + 4'd1;
                            tx_data  <= packet_byte(HEADER, hold, byte_idx + 4'd1);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ion_packet_serializer.sv
// Scoreboard bench: each accepted capture queues its 15 expected bytes and a
// negedge monitor pops one per UART handshake.
module tb_ion_packet_serializer;

    logic         clock;
    logic         resetn;
    logic [7:0]   ready;
    logic         data_valid;
    logic [109:0] din [8];
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;
    logic [4:0]   fifo_count;
    logic         overflow;

    int           checks = 0;
    int           errors = 0;
    logic [7:0]   exp_q [$];
    logic [7:0]   exp_byte;
    logic [7:0]   held;
    int           cycles;

    ion_packet_serializer #(
        .FIFO_DEPTH (4),
        .HEADER     (5'b10110)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .ready      (ready),
        .data_valid (data_valid),
        .data_in0   (din[0]),
        .data_in1   (din[1]),
        .data_in2   (din[2]),
        .data_in3   (din[3]),
        .data_in4   (din[4]),
        .data_in5   (din[5]),
        .data_in6   (din[6]),
        .data_in7   (din[7]),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte k of the frame {header, id, data, 2'b00}, taken MSB first.
    function automatic logic [7:0] frame_byte(input logic [2:0] id, input logic [109:0] d,
                                              input int k);
        logic [119:0] frame;
        frame = {5'b10110, id, d, 2'b00};
        for (int i = 0; i < k; i++) frame = frame << 8;
        return frame[119:112];
    endfunction

    task automatic capture(input logic [7:0] rdy, input bit accept);
        logic [2:0] id;
        id = 3'd0;
        for (int i = 7; i >= 0; i--) if (rdy[i]) id = 3'(i);
        @(posedge clock); #1;
        ready      = rdy;
        data_valid = 1'b1;
        if (accept) for (int k = 0; k < 15; k++) exp_q.push_back(frame_byte(id, din[id], k));
        @(posedge clock); #1;
        data_valid = 1'b0;
        ready      = 8'h00;
    endtask

    task automatic wait_tx_valid();
        int n;
        n = 0;
        while (!tx_valid && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (!tx_valid) check("tx_valid_timeout", 32'(tx_valid), 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || fifo_count != 5'd0) && n < 2000) begin
            @(posedge clock); #1;
            n++;
        end
        check("drain_queue", 32'(exp_q.size()), 0);
        check("drain_busy", 32'(busy), 0);
    endtask

    always @(negedge clock) begin
        if (resetn && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_byte", 32'(exp_q.size()), 1);
            end else begin
                exp_byte = exp_q.pop_front();
                check("tx_byte", 32'(tx_data), 32'(exp_byte));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn     = 1'b0;
        ready      = 8'h00;
        data_valid = 1'b0;
        tx_ready   = 1'b1;
        for (int i = 0; i < 8; i++) din[i] = '0;
        #12;
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_fifo_count", 32'(fifo_count), 0);
        check("rst_overflow", 32'(overflow), 0);
        @(posedge clock); #1;
        resetn = 1'b1;

        // Single packet with latency and duration checks.
        din[2] = 110'h1;
        capture(8'h04, 1'b1);
        check("lat_count", 32'(fifo_count), 1);
        check("lat_idle_busy", 32'(busy), 0);
        @(posedge clock); #1;
        check("lat_load_busy", 32'(busy), 1);
        check("lat_load_valid", 32'(tx_valid), 0);
        @(posedge clock); #1;
        check("lat_send_valid", 32'(tx_valid), 1);
        check("lat_header", 32'(tx_data), 32'h0B2);
        cycles = 2;
        while (busy && cycles < 100) begin
            @(posedge clock); #1;
            cycles++;
        end
        check("pkt_cycles", 32'(cycles), 17);
        check("single_queue", 32'(exp_q.size()), 0);

        // Lowest ready bit wins.
        din[4] = '1;
        din[7] = '0;
        capture(8'h90, 1'b1);
        wait_drain();

        // Backpressure on byte 3.
        din[1] = 110'h3123456789ABCDEF0123456789AB;
        capture(8'h02, 1'b1);
        wait_tx_valid();
        repeat (3) begin
            @(posedge clock); #1;
        end
        tx_ready = 1'b0;
        held = tx_data;
        check("bp_byte3", 32'(tx_data), 32'(frame_byte(3'd1, din[1], 3)));
        repeat (10) begin
            @(posedge clock); #1;
            check("bp_hold_data", 32'(tx_data), 32'(held));
            check("bp_hold_valid", 32'(tx_valid), 1);
        end
        tx_ready = 1'b1;
        wait_drain();

        // Overflow: one packet stalled in SEND, then five captures into a depth-4 FIFO.
        tx_ready = 1'b0;
        din[0] = 110'hA5;
        capture(8'h01, 1'b1);
        wait_tx_valid();
        din[1] = 110'h1111_2222;
        din[2] = 110'h3333_4444;
        din[3] = 110'h5555_6666;
        din[5] = 110'h7777_8888;
        din[6] = 110'h9999_AAAA;
        capture(8'h02, 1'b1);
        capture(8'h04, 1'b1);
        capture(8'h08, 1'b1);
        capture(8'h20, 1'b1);
        capture(8'h40, 1'b0);
        check("ovf_count", 32'(fifo_count), 4);
        check("ovf_flag", 32'(overflow), 1);
        tx_ready = 1'b1;
        wait_drain();
        repeat (20) @(posedge clock);
        #1;
        check("ovf_sticky", 32'(overflow), 1);

        // Reset after byte 7 with another packet still buffered.
        tx_ready = 1'b0;
        din[3] = 110'h0F0F_1234_5678;
        din[5] = 110'h2468_ACE0;
        capture(8'h08, 1'b1);
        capture(8'h20, 1'b1);
        wait_tx_valid();
        tx_ready = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        check("bytes_before_reset", 32'(exp_q.size()), 22);
        resetn = 1'b0;
        exp_q.delete();
        #1;
        check("rst_mid_valid", 32'(tx_valid), 0);
        check("rst_mid_count", 32'(fifo_count), 0);
        check("rst_mid_overflow", 32'(overflow), 0);
        check("rst_mid_busy", 32'(busy), 0);
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        repeat (30) @(posedge clock);
        #1;
        check("post_rst_valid", 32'(tx_valid), 0);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_count", 32'(fifo_count), 0);

        // Strobe with no ready flags is ignored.
        @(posedge clock); #1;
        ready      = 8'h00;
        data_valid = 1'b1;
        @(posedge clock); #1;
        data_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("ign_count", 32'(fifo_count), 0);
        check("ign_valid", 32'(tx_valid), 0);
        check("ign_busy", 32'(busy), 0);
        check("ign_overflow", 32'(overflow), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ion_packet_serializer.md
ION_PACKET_SERIALIZER -- requirements
Module: ion_packet_serializer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, packet slots buffered (power of two, 2..16).
REQ-002 SHALL have parameter HEADER, default 5'b10110, sync pattern in the upper five bits of each header byte.
REQ-003 SHALL have port clock  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ready  input  8  per-stream packet-available flags from the ion sensor stage.
REQ-006 SHALL have port data_valid  input  1  one-cycle strobe marking data_in0..7 as valid.
REQ-007 SHALL have ports data_in0..data_in7  input  110 each  sensor packets, one per stream.
REQ-008 SHALL have port tx_data  output  8  outgoing byte to the Bluetooth UART.
REQ-009 SHALL have port tx_valid  output  1  tx_data holds a valid byte.
REQ-010 SHALL have port tx_ready  input  1  UART accepts the byte this cycle.
REQ-011 SHALL have port busy  output  1  high while a packet is being emitted (LOAD or SEND).
REQ-012 SHALL have port fifo_count  output  5  packets currently buffered.
REQ-013 SHALL have port overflow  output  1  sticky: a packet was dropped.

Function
REQ-014 Capture SHALL occur on a rising clock edge with data_valid=1 and ready!=0; the stream id SHALL be the lowest set bit index of ready.
REQ-015 The captured entry SHALL be {id[2:0], data_in<id>[109:0]} (113 bits); other streams are ignored that cycle.
REQ-016 data_valid=1 with ready=0 SHALL be ignored; no state change.
REQ-017 Push SHALL be accepted only if fifo_count<FIFO_DEPTH at the start of the cycle; a same-cycle pop SHALL NOT free space for that push.
REQ-018 A rejected push SHALL set overflow to 1; overflow SHALL remain 1 until reset.
REQ-019 FIFO SHALL be first-in first-out; read/write pointers wrap modulo FIFO_DEPTH.
REQ-020 FSM SHALL have states IDLE, LOAD, SEND.
REQ-021 IDLE: tx_valid=0; if fifo_count!=0 -> LOAD, else stay.
REQ-022 LOAD: pop head entry into a 113-bit holding register, byte index=0; unconditionally -> SEND next cycle.
REQ-023 SEND: tx_valid=1; tx_data = byte[index]; on tx_valid&tx_ready index increments; on acceptance of byte 14 -> IDLE.
REQ-024 byte 0 SHALL be {HEADER[4:0], id[2:0]}; bytes 1..14 SHALL be {data[109:0], 2'b00} split MSB first (byte 1 = data[109:102], byte 14 = {data[5:0],2'b00}).
REQ-025 tx_data SHALL stay constant while tx_valid=1 and tx_ready=0.
REQ-026 Minimum latency: capture at edge N -> LOAD at N+1 -> first byte with tx_valid=1 at N+2 (FIFO previously empty, FSM in IDLE).
REQ-027 Minimum packet duration SHALL be 15 SEND cycles plus 1 LOAD plus 1 IDLE cycle (17 cycles with tx_ready held high).
REQ-028 Captures SHALL continue in all FSM states; emission never blocks capture.
REQ-029 busy SHALL be 1 in LOAD and SEND, 0 in IDLE.

Reset
REQ-030 resetn=0 SHALL asynchronously force: FSM=IDLE, pointers=0, fifo_count=0, overflow=0, tx_valid=0, tx_data=0, busy=0, byte index=0.
REQ-031 Reset mid-packet SHALL discard the packet in flight and all buffered entries; no partial byte emitted after release.

Structure
REQ-032 Shared package SHALL hold PKT_W=110, ENTRY_W=113, BYTES_PER_PKT=15, default HEADER, and the FSM state encoding (IDLE=2'b00, LOAD=2'b01, SEND=2'b10).
REQ-033 FIFO storage SHALL be one sub-module, packet_fifo (ENTRY_W wide, FIFO_DEPTH deep, push/pop/count/full/empty); FSM and byte mux stay in the top.

Verification
REQ-034 Single packet: ready=8'h04, data_in2=110'h1, data_valid pulse, tx_ready=1 -> bytes 8'hB2, 12 x 8'h00, 8'h00, 8'h04; busy falls after byte 14.
REQ-035 Priority: ready=8'h90, data_in4 all-ones, data_in7=0 -> header 8'hB4, bytes 1..13 = 8'hFF, byte 14 = 8'hFC; stream 7 not emitted.
REQ-036 Backpressure: tx_ready=0 for 10 cycles during byte 3 -> tx_data and tx_valid unchanged across all 10 cycles; sequence resumes without loss.
REQ-037 Overflow: tx_ready=0, 5 captures with FIFO_DEPTH=4 -> fifo_count=4, overflow=1; releasing tx_ready emits exactly packets 1..4 in order.
REQ-038 Reset mid-packet: resetn=0 after byte 7 -> tx_valid=0, fifo_count=0, overflow=0 immediately; no bytes after release until a new capture.
REQ-039 Ignored strobe: data_valid=1, ready=8'h00 -> fifo_count stays 0, tx_valid stays 0.
